// File: rtl/serial_pkg.sv
// Shared definitions for the serial UART blocks: FSM state encoding,
// the nominal 27 MHz / 115200 bit period and the FIFO occupancy width helper.
package serial_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned CLKS_PER_BIT_115200 = 234;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; power-of-2 depth, pointers
// wrap naturally, asynchronous active-low reset clears pointers and count.
module serial_tx_fifo import serial_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count_q != CW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) tail_d = tail_q + 1'b1;
        if (pop_ok)  head_d = head_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= din;
    end

    assign dout  = mem_q[head_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/serial_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised LSB-first with one
// start bit and STOP_BITS stop bits; back-to-back frames have no gap.
module serial_tx import serial_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               WR,
    input  logic [7:0]                         DIN,
    output logic                               READY,
    output logic                               TXD,
    output logic                               BUSY,
    output logic [count_width(FIFO_DEPTH)-1:0] COUNT
);

    localparam int unsigned CW = count_width(FIFO_DEPTH);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        baud_tick;
    logic        push;
    logic        pop;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic [CW-1:0] cnt_nxt;

    assign push = WR && ready_q;

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push),
        .pop   (pop),
        .din   (DIN),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (COUNT)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        baud_tick = (baud_q == 16'(CLKS_PER_BIT - 1));
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_STOP: begin
                // bit_q counts stop bits here; the last one chains straight into the next frame.
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_dout;
                            state_d = TX_START;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // TXD is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        case (state_q)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
        cnt_nxt = COUNT + CW'(push) - CW'(pop);
        ready_d = (cnt_nxt != CW'(FIFO_DEPTH));
        busy_d  = (state_d != TX_IDLE) || (cnt_nxt != '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign TXD   = txd_q;
    assign BUSY  = busy_q;
    assign READY = ready_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: a 115200-baud instance (234 clks/bit, 1 stop)
// and a fast instance (8 clks/bit, 2 stops), checked against hand-derived frames.
`timescale 1ns/1ps
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr1, wr2;
    logic [7:0] din1, din2;
    logic       rdy1, rdy2, txd1, txd2, busy1, busy2;
    logic [2:0] cnt1, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_tx #(
        .CLKS_PER_BIT (234),
        .FIFO_DEPTH   (4),
        .STOP_BITS    (1)
    ) u_dut (
        .CLK   (clk),
        .RST   (rst_n),
        .WR    (wr1),
        .DIN   (din1),
        .READY (rdy1),
        .TXD   (txd1),
        .BUSY  (busy1),
        .COUNT (cnt1)
    );

    serial_tx #(
        .CLKS_PER_BIT (8),
        .FIFO_DEPTH   (4),
        .STOP_BITS    (2)
    ) u_dut2 (
        .CLK   (clk),
        .RST   (rst_n),
        .WR    (wr2),
        .DIN   (din2),
        .READY (rdy2),
        .TXD   (txd2),
        .BUSY  (busy2),
        .COUNT (cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic mon_txd(input int d);
        return (d != 0) ? txd2 : txd1;
    endfunction

    function automatic logic mon_busy(input int d);
        return (d != 0) ? busy2 : busy1;
    endfunction

    function automatic logic mon_ready(input int d);
        return (d != 0) ? rdy2 : rdy1;
    endfunction

    // Called with the current cycle being frame index 'start' (0 = first start-bit cycle).
    task automatic check_frame(input int d, input logic [7:0] b, input int clks, input int stops,
                               input int start, input string tag,
                               output int busy_lo, output int ready_hi);
        int   total;
        int   mism;
        int   idx;
        logic e;
        logic [7:0] dec;
        total    = (9 + stops) * clks;
        mism     = 0;
        dec      = '0;
        busy_lo  = -1;
        ready_hi = -1;
        for (int i = start; i < total; i++) begin
            idx = i / clks;
            if (idx == 0)      e = 1'b0;
            else if (idx <= 8) e = b[idx-1];
            else               e = 1'b1;
            if (mon_txd(d) !== e) mism++;
            if (idx >= 1 && idx <= 8 && (i % clks) == clks / 2) dec[idx-1] = mon_txd(d);
            if (busy_lo < 0 && mon_busy(d) == 1'b0) busy_lo = i;
            if (ready_hi < 0 && mon_ready(d) == 1'b1) ready_hi = i;
            tick();
        end
        check($sformatf("%s_bits", tag), 32'(mism), 32'd0);
        check($sformatf("%s_byte", tag), 32'(dec), 32'(b));
    endtask

    task automatic burst4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input string tag);
        logic [7:0] bytes [4];
        int exp_cnt [4];
        int bl, rh;
        bytes   = '{b0, b1, b2, b3};
        exp_cnt = '{1, 1, 2, 3};
        wr1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din1 = bytes[k];
            tick();
            check($sformatf("%s_cnt%0d", tag, k), 32'(cnt1), exp_cnt[k]);
            check($sformatf("%s_rdy%0d", tag, k), 32'(rdy1), 32'd1);
        end
        wr1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_frame(0, bytes[k], 234, 1, (k == 0) ? 1 : 0, $sformatf("%s_f%0d", tag, k), bl, rh);
            check($sformatf("%s_busy%0d", tag, k), bl, (k == 3) ? 2339 : -1);
        end
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bl, rh, mism;
        rst_n = 1'b0;
        wr1 = 1'b0; wr2 = 1'b0;
        din1 = '0;  din2 = '0;
        repeat (3) tick();
        check("rst_txd",   32'(txd1),  32'd1);
        check("rst_ready", 32'(rdy1),  32'd1);
        check("rst_busy",  32'(busy1), 32'd0);
        check("rst_count", 32'(cnt1),  32'd0);
        check("rst_txd2",  32'(txd2),  32'd1);
        rst_n = 1'b1;
        tick();
        tick();

        // Single byte 0x55: start bit two edges after the write
        wr1 = 1'b1; din1 = 8'h55;
        tick();
        wr1 = 1'b0;
        check("t1_cnt_w",  32'(cnt1),  32'd1);
        check("t1_txd_w",  32'(txd1),  32'd1);
        check("t1_busy_w", 32'(busy1), 32'd1);
        tick();
        check("t1_cnt_pop", 32'(cnt1), 32'd0);
        check("t1_txd_pop", 32'(txd1), 32'd1);
        tick();
        check_frame(0, 8'h55, 234, 1, 0, "t1_f55", bl, rh);
        check("t1_busy_fall", bl, 2339);
        check("t1_txd_end",  32'(txd1),  32'd1);
        check("t1_busy_end", 32'(busy1), 32'd0);

        // Burst of four, back-to-back frames
        burst4(8'h41, 8'h42, 8'h43, 8'h44, "t2");

        // Hold WR until the FIFO fills; later bytes must be dropped
        wr1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            din1 = 8'(8'h10 + k);
            tick();
            check($sformatf("t3_rdy%0d", k), 32'(rdy1), (k < 4) ? 32'd1 : 32'd0);
            check($sformatf("t3_cnt%0d", k), 32'(cnt1), (k == 0) ? 32'd1 : ((k >= 4) ? 32'd4 : 32'(k)));
        end
        wr1 = 1'b0;
        check_frame(0, 8'h10, 234, 1, 5, "t3_f10", bl, rh);
        check("t3_ready_rise", rh, 2339);
        check("t3_busy_f10", bl, -1);
        for (int j = 1; j <= 4; j++) begin
            check_frame(0, 8'(8'h10 + j), 234, 1, 0, $sformatf("t3_f%0d", j), bl, rh);
            check($sformatf("t3_busy%0d", j), bl, (j == 4) ? 2339 : -1);
        end
        mism = 0;
        repeat (300) begin
            tick();
            if (txd1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 3'd0) mism++;
        end
        check("t3_no_dropped", 32'(mism), 32'd0);

        // Reset in the middle of a data bit with two bytes queued
        wr1 = 1'b1; din1 = 8'hA5;
        tick();
        din1 = 8'h01;
        tick();
        din1 = 8'h02;
        tick();
        wr1 = 1'b0;
        check("t4_cnt_q", 32'(cnt1), 32'd2);
        repeat (585) tick();
        check("t4_txd_bit1", 32'(txd1), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_txd_async",  32'(txd1),  32'd1);
        check("t4_cnt_async",  32'(cnt1),  32'd0);
        check("t4_busy_async", 32'(busy1), 32'd0);
        check("t4_rdy_async",  32'(rdy1),  32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mism = 0;
        repeat (3000) begin
            tick();
            if (txd1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 3'd0) mism++;
        end
        check("t4_quiet", 32'(mism), 32'd0);

        // Decode a mixed byte set
        burst4(8'h00, 8'hFF, 8'h5A, 8'hC3, "t6");

        // Two stop bits at 8 clocks per bit
        wr2 = 1'b1; din2 = 8'h00;
        tick();
        wr2 = 1'b0;
        tick();
        tick();
        check_frame(1, 8'h00, 8, 2, 0, "t5_f00", bl, rh);
        check("t5_busy_fall", bl, 87);

        // Write landing on the final stop cycle: one idle cycle, then start
        wr2 = 1'b1; din2 = 8'h00;
        tick();
        wr2 = 1'b0;
        tick();
        tick();
        check("t5b_start", 32'(txd2), 32'd0);
        repeat (86) tick();
        check("t5b_stop", 32'(txd2), 32'd1);
        wr2 = 1'b1; din2 = 8'hC3;
        tick();
        wr2 = 1'b0;
        check("t5b_cnt_late",  32'(cnt2),  32'd1);
        check("t5b_busy_late", 32'(busy2), 32'd1);
        check("t5b_txd_last",  32'(txd2),  32'd1);
        tick();
        check("t5b_txd_idle", 32'(txd2), 32'd1);
        check("t5b_cnt_pop",  32'(cnt2), 32'd0);
        tick();
        check_frame(1, 8'hC3, 8, 2, 0, "t5b_fC3", bl, rh);
        check("t5b_busy_fall", bl, 87);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- 8N1 UART transmitter. It is the transmit-side counterpart to the design's serial receiver and uses the same 27 MHz / 115200 baud framing.
- Host logic pushes bytes through a small FIFO using a valid/ready write port.
- The block serialises each byte LSB-first on TXD with 1 start bit and STOP_BITS stop bits.
- It sits between user logic (echo path, debug console) and the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 234, CLK cycles per serial bit (27,000,000 / 115200, rounded). Legal range is 4..65535.
- FIFO_DEPTH, 4, number of transmit FIFO entries. Must be a power of 2, range 2..16.
- STOP_BITS, 1, number of stop bits. Only 1 or 2 is legal.

Ports:
- CLK  in  1  system clock (27 MHz).
- RST  in  1  asynchronous active-low reset. Asserting it resets all state immediately; deassertion is synchronous to CLK at the top level.
- WR  in  1  write strobe. Qualifies DIN.
- DIN  in  8  byte to transmit.
- READY  out  1  FIFO not full. A write is accepted in a cycle only when WR=1 and READY=1.
- TXD  out  1  serial output. Idle level is high.
- BUSY  out  1  high when a frame is in progress or the FIFO is non-empty.
- COUNT  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (RST=0): TXD=1, READY=1, BUSY=0, COUNT=0. The FSM goes to IDLE, the FIFO pointers clear, the baud counter clears and the bit counter clears. All outputs are registered.
- Reset mid-frame: TXD returns to 1 asynchronously, the partial frame is abandoned, and FIFO contents are discarded.
- Write acceptance:
  - WR=1 with READY=1 stores DIN at the tail on that rising edge. COUNT increments the next cycle.
  - WR=1 with READY=0 is ignored. The byte is dropped and there is no error flag; the host must honour READY.
  - When the FIFO is full, a write is never accepted, even in a cycle where the FSM pops. READY is a registered !full.
- FIFO: head/tail pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. A simultaneous push and pop with 0 < COUNT < FIFO_DEPTH leaves COUNT unchanged.
- FSM states and transitions:
  - IDLE: TXD=1. If COUNT>0, pop the head into a shift register, load the baud counter and go to START.
  - START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TXD=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, if COUNT>0, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Latency: for a write at edge N into an empty FIFO with the FSM in IDLE, TXD falls at edge N+2 (edge N+1 pops, edge N+2 drives the start bit).
- Frame length: exactly (9+STOP_BITS)*CLKS_PER_BIT cycles. Back-to-back frames have zero gap.
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1. The terminal count ends the bit. There is no drift or accumulation across bits.
- BUSY = (state != IDLE) || (COUNT != 0), registered. It falls on the cycle the FSM re-enters IDLE with an empty FIFO.
- A byte written during the final STOP cycle of a frame, into an otherwise empty FIFO, is not visible to the pop decision at that edge. The FSM enters IDLE for one cycle and then starts.

Decomposition:
- Shared package serial_pkg holds:
  - state encoding localparams: TX_IDLE=0, TX_START=1, TX_DATA=2, TX_STOP=3;
  - CLKS_PER_BIT_115200=234;
  - the width helper used by COUNT.
- One sub-module, serial_tx_fifo: a synchronous FIFO with push/pop/full/empty/count and the same async active-low reset. The FSM and baud counter stay in serial_tx.

Test Plan:
1. Reset, then write 0x55 once (CLKS_PER_BIT=234) -> TXD low at write+2 edges for 234 cycles, then 1,0,1,0,1,0,1,0 (LSB first), each 234 cycles, then high. BUSY drops after 2340 cycles.
2. Burst-write 0x41,0x42,0x43,0x44 on consecutive cycles (FIFO_DEPTH=4) -> all accepted (the first is popped at once). Observe 4 frames with zero inter-frame gap, COUNT peaks at 3, and the decoded bytes are A,B,C,D.
3. Hold WR=1 with incrementing DIN until READY=0 -> READY falls when COUNT=4. Bytes presented while READY=0 never appear on TXD, and READY rises the cycle after a pop.
4. Assert RST mid-DATA of 0xA5 with 2 bytes queued -> TXD=1 immediately, COUNT=0, and no further frames until a new write.
5. STOP_BITS=2, CLKS_PER_BIT=8, write 0x00 -> frame is 88 cycles: 72 cycles low (start + 8 zeros), then 16 cycles high.
6. Loopback TXD into the design's serial receiver at 115200 and send 0x00, 0xFF, 0x5A, 0xC3 -> the receiver's flag pulses 4 times with identical bytes.
